// File: rtl/cpu_loader_if.sv
// Stream bundle between the host and the loader: command/data input and readback output.
// The host owns the master side; the loader owns the slave side.
interface cpu_loader_if;
  logic        s_valid;
  logic        s_ready;
  logic [31:0] s_data;
  logic        m_valid;
  logic        m_ready;
  logic [31:0] m_data;

  modport master (
    output s_valid, s_data, m_ready,
    input  s_ready, m_valid, m_data
  );

  modport slave (
    input  s_valid, s_data, m_ready,
    output s_ready, m_valid, m_data
  );
endinterface

// File: rtl/cpu_loader.sv
// Host bridge: loads instruction/data memory from a command stream, runs the core for
// a counted number of cycles, and streams data memory back one word at a time.
module cpu_loader #(
  parameter int unsigned ADDR_STEP = 4,
  parameter int unsigned RD_LAT    = 1
) (
  input  logic         clk,
  input  logic         arst_n,
  cpu_loader_if.slave  bus,
  output logic         cpu_enable,
  output logic [31:0]  imem_addr,
  output logic         imem_wen,
  output logic         imem_ren,
  output logic [31:0]  imem_wdata,
  output logic [31:0]  dmem_addr,
  output logic         dmem_wen,
  output logic         dmem_ren,
  output logic [31:0]  dmem_wdata,
  input  logic [31:0]  dmem_rdata,
  output logic         busy
);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] LOAD     = 3'd1;
  localparam logic [2:0] RUN      = 3'd2;
  localparam logic [2:0] RD_ISSUE = 3'd3;
  localparam logic [2:0] RD_WAIT  = 3'd4;
  localparam logic [2:0] RD_OUT   = 3'd5;

  localparam logic [1:0] OP_LOAD_I = 2'b00;
  localparam logic [1:0] OP_LOAD_D = 2'b01;
  localparam logic [1:0] OP_RUN    = 2'b10;

  localparam int WAIT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  logic [2:0]        state;
  logic [2:0]        state_nxt;
  logic              to_dmem;
  logic [13:0]       base;
  logic [15:0]       cnt_n;
  logic [15:0]       idx;
  logic [15:0]       run_left;
  logic [WAIT_W-1:0] wait_left;
  logic              m_valid_q;
  logic [31:0]       m_data_q;

  logic [1:0]  hdr_op;
  logic [13:0] hdr_base;
  logic [15:0] hdr_n;
  logic        s_hs;
  logic        last;

  assign hdr_op   = bus.s_data[31:30];
  assign hdr_base = bus.s_data[29:16];
  assign hdr_n    = bus.s_data[15:0];
  assign s_hs     = bus.s_valid & bus.s_ready;
  assign last     = (idx == cnt_n - 16'd1);

  // Ready is held low while reset is applied so no word is taken during the reset cycle.
  assign bus.s_ready = arst_n & ((state == IDLE) | (state == LOAD));
  assign bus.m_valid = m_valid_q;
  assign bus.m_data  = m_data_q;
  assign imem_ren    = 1'b0;

  // base+k is formed in 17 bits, then scaled; the product wraps modulo 2^32.
  function automatic logic [31:0] word_addr(input logic [13:0] b, input logic [15:0] k);
    logic [16:0] sum;
    sum = {3'b000, b} + {1'b0, k};
    return {15'd0, sum} * 32'(ADDR_STEP);
  endfunction

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:
        if (s_hs && hdr_n != 16'd0) begin
          case (hdr_op)
            OP_LOAD_I, OP_LOAD_D: state_nxt = LOAD;
            OP_RUN:               state_nxt = RUN;
            default:              state_nxt = RD_ISSUE;
          endcase
        end
      LOAD:     if (s_hs && last) state_nxt = IDLE;
      RUN:      if (run_left == 16'd0) state_nxt = IDLE;
      RD_ISSUE: state_nxt = RD_WAIT;
      RD_WAIT:  if (wait_left == '0) state_nxt = RD_OUT;
      RD_OUT:   if (bus.m_ready) state_nxt = last ? IDLE : RD_ISSUE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!arst_n) begin
      state      <= IDLE;
      busy       <= 1'b0;
      to_dmem    <= 1'b0;
      base       <= '0;
      cnt_n      <= '0;
      idx        <= '0;
      run_left   <= '0;
      wait_left  <= '0;
      m_valid_q  <= 1'b0;
      m_data_q   <= '0;
      cpu_enable <= 1'b0;
      imem_addr  <= '0;
      imem_wen   <= 1'b0;
      imem_wdata <= '0;
      dmem_addr  <= '0;
      dmem_wen   <= 1'b0;
      dmem_ren   <= 1'b0;
      dmem_wdata <= '0;
    end else begin
      state    <= state_nxt;
      busy     <= (state_nxt != IDLE);
      imem_wen <= 1'b0;
      dmem_wen <= 1'b0;
      dmem_ren <= 1'b0;
      case (state)
        IDLE:
          if (s_hs) begin
            base    <= hdr_base;
            cnt_n   <= hdr_n;
            idx     <= '0;
            to_dmem <= (hdr_op == OP_LOAD_D);
            if (hdr_n != 16'd0) begin
              if (hdr_op == OP_RUN) begin
                cpu_enable <= 1'b1;
                run_left   <= hdr_n - 16'd1;
              end else if (hdr_op != OP_LOAD_I && hdr_op != OP_LOAD_D) begin
                dmem_ren  <= 1'b1;
                dmem_addr <= word_addr(hdr_base, 16'd0);
              end
            end
          end
        LOAD:
          if (s_hs) begin
            idx <= idx + 16'd1;
            if (to_dmem) begin
              dmem_wen   <= 1'b1;
              dmem_addr  <= word_addr(base, idx);
              dmem_wdata <= bus.s_data;
            end else begin
              imem_wen   <= 1'b1;
              imem_addr  <= word_addr(base, idx);
              imem_wdata <= bus.s_data;
            end
          end
        RUN:
          if (run_left == 16'd0) cpu_enable <= 1'b0;
          else                   run_left   <= run_left - 16'd1;
        RD_ISSUE:
          wait_left <= WAIT_W'(RD_LAT - 1);
        RD_WAIT:
          if (wait_left == '0) begin
            m_data_q  <= dmem_rdata;
            m_valid_q <= 1'b1;
          end else begin
            wait_left <= wait_left - 1'b1;
          end
        RD_OUT:
          if (bus.m_ready) begin
            m_valid_q <= 1'b0;
            if (!last) begin
              idx       <= idx + 16'd1;
              dmem_ren  <= 1'b1;
              dmem_addr <= word_addr(base, idx + 16'd1);
            end
          end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_loader.sv
// Scoreboard bench: the driver pushes expected writes, reads and run lengths computed from
// the command rules; a negedge monitor pops and compares whenever the DUT presents activity.
module tb_cpu_loader;
  localparam logic [1:0] OP_LI = 2'b00;
  localparam logic [1:0] OP_LD = 2'b01;
  localparam logic [1:0] OP_RN = 2'b10;
  localparam logic [1:0] OP_RD = 2'b11;

  logic        clk = 1'b0;
  logic        arst_n;
  logic        cpu_enable, imem_wen, imem_ren, dmem_wen, dmem_ren, busy;
  logic [31:0] imem_addr, imem_wdata, dmem_addr, dmem_wdata;
  logic [31:0] dmem_rdata = '0;

  cpu_loader_if bus();

  cpu_loader #(.ADDR_STEP(4), .RD_LAT(1)) dut (
    .clk(clk), .arst_n(arst_n), .bus(bus),
    .cpu_enable(cpu_enable),
    .imem_addr(imem_addr), .imem_wen(imem_wen), .imem_ren(imem_ren), .imem_wdata(imem_wdata),
    .dmem_addr(dmem_addr), .dmem_wen(dmem_wen), .dmem_ren(dmem_ren), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  logic [31:0] exp_iw_addr[$], exp_iw_data[$], exp_dw_addr[$], exp_dw_data[$];
  int          exp_iw_cyc[$], exp_dw_cyc[$];
  logic [31:0] exp_rd_addr[$], exp_rd_data[$];
  int          exp_rd_cyc[$];
  int          exp_run_len[$], exp_run_start[$];
  logic [31:0] ref_mem[logic [31:0]];
  logic [31:0] env_mem[logic [31:0]];
  int          word_acc[$];
  int          hdr_acc;
  int          mr_mode = 0;
  logic        mon_en = 1'b0;

  function automatic logic [31:0] default_word(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [31:0] ref_read(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : default_word(a);
  endfunction

  // External data memory with one cycle of read latency; rdata is noise when not reading.
  always @(posedge clk) begin
    if (dmem_ren === 1'b1)
      dmem_rdata <= env_mem.exists(dmem_addr) ? env_mem[dmem_addr] : default_word(dmem_addr);
    else
      dmem_rdata <= $urandom;
    if (dmem_wen === 1'b1) env_mem[dmem_addr] = dmem_wdata;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %h, want %h (cycle %0d)", name, actual, expected, cycle);
    end
  endtask

  initial begin
    bus.m_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (mr_mode)
        1:       bus.m_ready = 1'b0;
        2:       bus.m_ready = 1'b1;
        default: bus.m_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  int          run_len = 0;
  int          cur_len = -1;
  logic        stall_prev = 1'b0;
  logic [31:0] stall_data;

  always @(negedge clk) begin
    if (mon_en) begin
      checkOutput("imem_ren idle", {31'd0, imem_ren}, 32'd0);
      if (imem_wen === 1'b1) begin
        if (exp_iw_addr.size() == 0) checkOutput("unexpected imem write", 32'd1, 32'd0);
        else begin
          checkOutput("imem addr", imem_addr, exp_iw_addr.pop_front());
          checkOutput("imem data", imem_wdata, exp_iw_data.pop_front());
          checkOutput("imem write cycle", cycle, exp_iw_cyc.pop_front());
        end
      end
      if (dmem_wen === 1'b1) begin
        if (exp_dw_addr.size() == 0) checkOutput("unexpected dmem write", 32'd1, 32'd0);
        else begin
          checkOutput("dmem addr", dmem_addr, exp_dw_addr.pop_front());
          checkOutput("dmem data", dmem_wdata, exp_dw_data.pop_front());
          checkOutput("dmem write cycle", cycle, exp_dw_cyc.pop_front());
        end
      end
      if (dmem_ren === 1'b1) begin
        if (exp_rd_addr.size() == 0) checkOutput("unexpected dmem read", 32'd1, 32'd0);
        else begin
          int ec;
          checkOutput("read addr", dmem_addr, exp_rd_addr.pop_front());
          ec = exp_rd_cyc.pop_front();
          if (ec >= 0) checkOutput("first read cycle", cycle, ec);
        end
      end
      if (stall_prev && bus.m_valid === 1'b1) checkOutput("m_data stable", bus.m_data, stall_data);
      if (bus.m_valid === 1'b1 && bus.m_ready === 1'b1) begin
        if (exp_rd_data.size() == 0) checkOutput("unexpected readback", 32'd1, 32'd0);
        else checkOutput("readback data", bus.m_data, exp_rd_data.pop_front());
      end
      stall_prev = (bus.m_valid === 1'b1) && (bus.m_ready !== 1'b1);
      stall_data = bus.m_data;
      if (cpu_enable === 1'b1) begin
        if (run_len == 0) begin
          if (exp_run_len.size() == 0) begin
            checkOutput("unexpected enable", 32'd1, 32'd0);
            cur_len = -1;
          end else begin
            cur_len = exp_run_len.pop_front();
            checkOutput("run start cycle", cycle, exp_run_start.pop_front());
          end
        end
        run_len++;
        checkOutput("busy in run", {31'd0, busy}, 32'd1);
        checkOutput("s_ready in run", {31'd0, bus.s_ready}, 32'd0);
      end else if (run_len > 0) begin
        if (cur_len >= 0) checkOutput("run length", run_len, cur_len);
        run_len = 0;
      end
    end
  end

  // Presents one word and returns the cycle of its handshake; called at posedge+1.
  task automatic applyStimulus(input logic [31:0] data, input int gap, output int acc);
    logic hs;
    int   waited;
    bus.s_valid = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
    bus.s_valid = 1'b1;
    bus.s_data  = data;
    hs = 1'b0;
    waited = 0;
    acc = -1;
    while (acc < 0 && waited < 200) begin
      @(negedge clk);
      hs = bus.s_ready;
      @(posedge clk); #1;
      waited++;
      if (hs === 1'b1) acc = cycle;
    end
    bus.s_valid = 1'b0;
    if (acc < 0) checkOutput("handshake timeout", 32'd0, 32'd1);
  endtask

  task automatic issue(input logic [1:0] op, input logic [13:0] base, input logic [15:0] n, input int gap);
    int          acc;
    logic [31:0] w, a;
    word_acc.delete();
    applyStimulus({op, base, n}, 0, acc);
    hdr_acc = acc;
    if (n == 16'd0) return;
    for (int k = 0; k < int'(n); k++) begin
      a = (32'(base) + 32'(k)) * 32'd4;
      if (op == OP_LI || op == OP_LD) begin
        w = $urandom;
        applyStimulus(w, (gap < 0) ? $urandom_range(0, 2) : gap, acc);
        word_acc.push_back(acc);
        if (op == OP_LI) begin
          exp_iw_addr.push_back(a); exp_iw_data.push_back(w); exp_iw_cyc.push_back(acc);
        end else begin
          exp_dw_addr.push_back(a); exp_dw_data.push_back(w); exp_dw_cyc.push_back(acc);
          ref_mem[a] = w;
        end
      end else if (op == OP_RD) begin
        exp_rd_addr.push_back(a);
        exp_rd_data.push_back(ref_read(a));
        exp_rd_cyc.push_back(k == 0 ? hdr_acc : -1);
      end
    end
    if (op == OP_RN) begin
      exp_run_len.push_back(int'(n));
      exp_run_start.push_back(hdr_acc);
    end
  endtask

  task automatic waitIdle();
    int w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (!(busy === 1'b0 && run_len == 0 && exp_iw_addr.size() == 0 && exp_dw_addr.size() == 0 &&
                 exp_rd_data.size() == 0 && exp_run_len.size() == 0) && w < 400);
    if (w >= 400) checkOutput("idle timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
  endtask

  initial begin
    #900000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int          acc, prev, w;
    logic [13:0] bases[$];
    logic [1:0]  op;
    logic [13:0] b;
    logic [15:0] n;

    arst_n = 1'b0;
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset s_ready", {31'd0, bus.s_ready}, 32'd0);
    checkOutput("reset busy", {31'd0, busy}, 32'd0);
    checkOutput("reset enable", {31'd0, cpu_enable}, 32'd0);
    checkOutput("reset m_valid", {31'd0, bus.m_valid}, 32'd0);
    checkOutput("reset strobes", {29'd0, imem_wen, dmem_wen, dmem_ren}, 32'd0);
    @(posedge clk); #1;
    arst_n = 1'b1;
    mon_en = 1'b1;
    @(negedge clk);
    checkOutput("s_ready after reset", {31'd0, bus.s_ready}, 32'd1);
    @(posedge clk); #1;

    $display("[TB] LOAD_I base=2 n=3 back-to-back");
    issue(OP_LI, 14'd2, 16'd3, 0);
    checkOutput("b2b spacing", word_acc[2] - word_acc[0], 32'd2);
    waitIdle();

    $display("[TB] LOAD_D base=0 n=2 with 3-cycle gap");
    issue(OP_LD, 14'd0, 16'd2, 3);
    checkOutput("gap spacing", word_acc[1] - word_acc[0], 32'd4);
    waitIdle();

    $display("[TB] RUN n=5");
    issue(OP_RN, 14'd0, 16'd5, 0);
    waitIdle();

    $display("[TB] READ_D base=0 n=2 with m_ready held low");
    mr_mode = 1;
    issue(OP_RD, 14'd0, 16'd2, 0);
    w = 0;
    do begin @(negedge clk); w++; end while (bus.m_valid !== 1'b1 && w < 50);
    if (w >= 50) checkOutput("m_valid timeout", 32'd0, 32'd1);
    repeat (4) @(negedge clk);
    mr_mode = 2;
    waitIdle();
    mr_mode = 0;

    $display("[TB] zero-length headers");
    prev = 0;
    for (int i = 0; i < 4; i++) begin
      applyStimulus({2'(i), 14'd5, 16'd0}, 0, acc);
      if (i > 0) checkOutput("n0 next accept", acc - prev, 32'd1);
      prev = acc;
    end
    issue(OP_LD, 14'd100, 16'd1, 0);
    checkOutput("n0 then load accept", hdr_acc - prev, 32'd1);
    waitIdle();

    $display("[TB] reset mid-LOAD");
    applyStimulus({OP_LD, 14'd40, 16'd4}, 0, acc);
    applyStimulus(32'hCAFE_0001, 0, acc);
    exp_dw_addr.push_back(32'd160); exp_dw_data.push_back(32'hCAFE_0001); exp_dw_cyc.push_back(acc);
    ref_mem[32'd160] = 32'hCAFE_0001;
    arst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checkOutput("abort s_ready", {31'd0, bus.s_ready}, 32'd0);
    checkOutput("abort busy", {31'd0, busy}, 32'd0);
    checkOutput("abort strobes", {28'd0, imem_wen, dmem_wen, dmem_ren, cpu_enable}, 32'd0);
    checkOutput("abort dmem_addr", dmem_addr, 32'd0);
    @(posedge clk); #1;
    arst_n = 1'b1;
    @(negedge clk);
    checkOutput("abort write count", exp_dw_addr.size(), 32'd0);
    @(posedge clk); #1;
    issue(OP_LD, 14'd40, 16'd4, -1);
    waitIdle();
    issue(OP_RD, 14'd40, 16'd4, 0);
    waitIdle();

    $display("[TB] randomized commands");
    bases.push_back(14'd40);
    for (int t = 0; t < 40; t++) begin
      op = 2'($urandom_range(0, 3));
      n  = ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom_range(1, 6));
      b  = 14'($urandom_range(0, 16383));
      if (op == OP_RD && $urandom_range(0, 3) != 0) b = bases[$urandom_range(0, bases.size() - 1)];
      if (op == OP_LD) bases.push_back(b);
      issue(op, b, n, -1);
    end
    waitIdle();

    checkOutput("imem writes left", exp_iw_addr.size(), 32'd0);
    checkOutput("dmem writes left", exp_dw_addr.size(), 32'd0);
    checkOutput("reads left", exp_rd_addr.size(), 32'd0);
    checkOutput("runs left", exp_run_len.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cpu_loader.md
CPU_LOADER -- requirements
Module: cpu_loader

Upstream host bridge. It loads instruction and data memory through the external ports, runs the core for a set number of cycles, and streams data memory back.

Interface
REQ-001 Parameter ADDR_STEP, default 4: byte increment between consecutive word addresses.
REQ-002 Parameter RD_LAT, default 1: data-memory external read latency, in cycles from dmem_ren to valid dmem_rdata.
REQ-003 Port clk, input, 1: sole clock, rising edge.
REQ-004 Port arst_n, input, 1: reset, synchronous, active-low.
REQ-005 Port s_valid / s_ready / s_data, in/out/in, 1/1/32: command-and-data input stream.
REQ-006 Port m_valid / m_ready / m_data, out/in/out, 1/1/32: readback output stream.
REQ-007 Port cpu_enable, output, 1: drives the core enable.
REQ-008 Port imem_addr / imem_wen / imem_ren / imem_wdata, output, 32/1/1/32: instruction-memory external port.
REQ-009 Port dmem_addr / dmem_wen / dmem_ren / dmem_wdata, output, 32/1/1/32: data-memory external port.
REQ-010 Port dmem_rdata, input, 32: data-memory external read data.
REQ-011 Port busy, output, 1: high whenever the state is not IDLE.

Function
REQ-012 Header word fields: op = s_data[31:30], base = s_data[29:16] (word index), n = s_data[15:0].
REQ-013 Op encoding: 00 LOAD_I; 01 LOAD_D; 10 RUN; 11 READ_D.
REQ-014 FSM states: IDLE, LOAD, RUN, RD_ISSUE, RD_WAIT, RD_OUT.
REQ-015 In IDLE, s_ready=1 and a handshake (s_valid & s_ready) captures the header.
REQ-016 Header with n=0: the block consumes it, stays in IDLE, and produces no memory access and no enable pulse.
REQ-017 LOAD_I/LOAD_D with n>0 -> LOAD; s_ready=1 in LOAD; word k (k=0..n-1) is accepted on its handshake.
REQ-018 Each accepted word k produces, in the next cycle, a one-cycle write on the selected port: wen=1, addr=(base+k)*ADDR_STEP, wdata=word; the other port stays idle.
REQ-019 LOAD sustains one word per cycle; s_valid gaps insert idle cycles with wen=0.
REQ-020 After word n-1 is accepted -> IDLE; its write still appears in the following cycle.
REQ-021 RUN with n>0: cpu_enable=1 for exactly n consecutive cycles, starting the cycle after header acceptance, then -> IDLE; s_ready=0 during RUN.
REQ-022 READ_D with n>0 -> RD_ISSUE: one-cycle dmem_ren=1 with dmem_addr=(base+k)*ADDR_STEP, then RD_WAIT for RD_LAT cycles.
REQ-023 At the end of RD_WAIT, the block captures dmem_rdata into m_data and enters RD_OUT with m_valid=1.
REQ-024 In RD_OUT, m_valid and m_data stay stable until m_ready; on the handshake, k increments and the FSM -> RD_ISSUE, or -> IDLE after word n-1.
REQ-025 READ_D keeps at most one read outstanding; s_ready=0 in every RD_* state.
REQ-026 Address arithmetic is 32-bit unsigned and wraps modulo 2^32; base+k is computed in 17 bits before scaling.
REQ-027 Outside their stated cycles, cpu_enable, all wen/ren strobes and m_valid are 0; the imem_ren and dmem_ren outputs are never asserted except per REQ-022.
REQ-028 All outputs are registered; s_ready is decoded from the state register.

Reset
REQ-029 With arst_n=0 at a rising edge, the next state is IDLE; all counters clear to 0 and every output register clears to 0.
REQ-030 During the reset cycle s_ready=0 and busy=0; s_ready=1 from the first cycle after arst_n returns high.
REQ-031 Reset asserted in any state aborts the operation with no further writes, enable cycles or m_valid, and pending readback data is discarded.

Verification
REQ-032 LOAD_I base=2, n=3, words A,B,C back-to-back -> imem_wen pulses on 3 consecutive cycles at addr 8, 12, 16 with data A, B, C; dmem untouched.
REQ-033 LOAD_D n=2 with a 3-cycle s_valid gap between the words -> exactly 2 dmem writes, separated by the gap, at addr 0 and 4.
REQ-034 RUN n=5 -> cpu_enable high for exactly 5 cycles, busy high throughout, s_ready=0 until return to IDLE.
REQ-035 READ_D base=0, n=2 with m_ready held low for 4 cycles -> m_data stable, a single dmem_ren per word, words returned in order.
REQ-036 Header with n=0 for each op -> no strobes and no enable; the next header is accepted in the following cycle.
REQ-037 Reset asserted mid-LOAD after 1 of 4 words -> no further writes, IDLE with all outputs 0, and a fresh LOAD then completes normally.
